sram_array_ctrl: RTL and testbench
==================================

SRAM_ARRAY_CTRL -- requirements
Module: sram_array_ctrl

Interface
REQ-001 SHALL have parameters: DEPTH, 1024, entries; ADDR_W, 10, address width; DATA_W, 13, data width.
REQ-002 SHALL have ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- init_req  in  1  request a full array re-clear.
- init_done  out  1  high while in RUN.
- rd0_req_valid / rd0_req_ready  in / out  1  read requester 0 handshake.
- rd0_req_addr  in  ADDR_W  read requester 0 address.
- rd0_resp_valid  out  1  read response valid, requester 0.
- rd0_resp_data  out  DATA_W  read response data, requester 0.
- rd1_*  same set for requester 1.
- wr_req_valid / wr_req_ready  in / out  1  write handshake.
- wr_req_addr  in  ADDR_W  write address.
- wr_req_data  in  DATA_W  write data.
- sram_r_en / sram_r_addr  out  1 / ADDR_W  macro read port.
- sram_r_data  in  DATA_W  macro read data, valid the cycle after sram_r_en.
- sram_w_en / sram_w_addr / sram_w_data  out  1 / ADDR_W / DATA_W  macro write port.

Function
REQ-003 SHALL implement FSM states WAIT, INIT, RUN; reset state WAIT.
REQ-004 WAIT SHALL last exactly one cycle after reset release, then go to INIT with the clear counter at 0.
REQ-005 In INIT SHALL drive sram_w_en=1, sram_w_addr=counter, sram_w_data=0; counter increments by 1 each cycle.
REQ-006 INIT SHALL go to RUN after the cycle writing DEPTH-1; INIT lasts exactly DEPTH cycles.
REQ-007 In RUN, init_req=1 SHALL move the FSM to INIT next cycle with counter 0; init_req SHALL be ignored in WAIT and INIT.
REQ-008 init_done SHALL equal (state==RUN).
REQ-009 In WAIT and INIT, all req_ready outputs SHALL be 0 and sram_r_en SHALL be 0.
REQ-010 In RUN, wr_req_ready SHALL be 1; a write fires when wr_req_valid=1.
REQ-011 A write fire SHALL drive sram_w_en=1 with the request address and data in the same cycle, combinationally.
REQ-012 In RUN, at most one read SHALL be granted per cycle, chosen by round-robin between rd0 and rd1.
REQ-013 A single valid requester SHALL be granted.
REQ-014 When both requesters are valid, the one selected by the priority pointer SHALL be granted.
REQ-015 The pointer SHALL move to the non-granted requester after every grant and hold when there is no grant; the reset value favours rd0.
REQ-016 rdN_req_ready SHALL be 1 only for the granted requester and only when its valid=1; ready SHALL NOT depend on the other requester's ready.
REQ-017 A read grant SHALL drive sram_r_en=1 and sram_r_addr=granted address in the same cycle.
REQ-018 With no read grant, sram_r_en SHALL be 0 and sram_r_addr SHALL hold its last value.
REQ-019 For a grant in cycle t, rdN_resp_valid SHALL be 1 in cycle t+1 only, for the granted requester only.
REQ-020 The response data SHALL be sram_r_data unless REQ-021 applies.
REQ-021 Bypass: if a write fires in cycle t to the same address as the read granted in cycle t, the response in t+1 SHALL carry the written data from a captured register, not sram_r_data.
REQ-022 A write in cycle t+1 SHALL NOT affect the response of a cycle-t read.
REQ-023 A read granted in the last RUN cycle before INIT (init_req) SHALL still deliver its response in the following cycle.
REQ-024 rdN_resp_data SHALL be don't-care when rdN_resp_valid=0.
REQ-025 Addresses SHALL be used unmodified; the block SHALL NOT range-check against DEPTH.

Reset
REQ-026 While reset=0, the block SHALL hold: state=WAIT, counter=0, pointer=rd0, all resp_valid=0, bypass flag=0, sram_w_en=0, sram_r_en=0, all ready=0, init_done=0.
REQ-027 Reset assertion mid-INIT or mid-RUN SHALL abort immediately; an in-flight response SHALL be dropped (resp_valid=0).

Verification
REQ-028 Release reset -> 1 WAIT cycle, then 1024 consecutive writes of 0 to addresses 0..1023, then init_done=1 and readies active.
REQ-029 After init, write addr 5 = 0x1ABC, then read addr 5 on rd0 a later cycle -> rd0_resp_valid exactly one cycle after grant, data 0x1ABC; reading addr 6 -> 0.
REQ-030 rd0 and rd1 valid every cycle for 6 cycles -> grants alternate rd0, rd1, rd0, ...; each response arrives on the matching port only.
REQ-031 Same-cycle write addr 9 = 0x0F0F and rd1 read addr 9 -> rd1_resp_data=0x0F0F.
REQ-032 Read addr 3 granted in cycle t, write addr 3 = 0x0055 in t+1 -> response returns the old value.
REQ-033 init_req mid-traffic -> next cycle all readies 0 and the clear restarts at 0; reset asserted mid-INIT -> outputs immediately take reset values.

Source files
------------

// File: rtl/sram_array_ctrl.sv
// SRAM array controller: clears the whole array after reset or on request, then
// serves one writer and two round-robin readers with same-cycle write-to-read bypass.
module sram_array_ctrl #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_req,
    output logic              init_done,
    input  logic              rd0_req_valid,
    output logic              rd0_req_ready,
    input  logic [ADDR_W-1:0] rd0_req_addr,
    output logic              rd0_resp_valid,
    output logic [DATA_W-1:0] rd0_resp_data,
    input  logic              rd1_req_valid,
    output logic              rd1_req_ready,
    input  logic [ADDR_W-1:0] rd1_req_addr,
    output logic              rd1_resp_valid,
    output logic [DATA_W-1:0] rd1_resp_data,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    output logic              sram_r_en,
    output logic [ADDR_W-1:0] sram_r_addr,
    input  logic [DATA_W-1:0] sram_r_data,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_w_addr,
    output logic [DATA_W-1:0] sram_w_data
);

    typedef enum logic [1:0] {ST_WAIT, ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic              ptr_q, ptr_d;
    logic              rv0_q, rv0_d;
    logic              rv1_q, rv1_d;
    logic              byp_q, byp_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;

    logic              run;
    logic              gnt0;
    logic              gnt1;
    logic              wr_fire;
    logic [ADDR_W-1:0] gnt_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // ptr_q=0 favours rd0; each ready looks only at valids and the pointer.
    always_comb begin
        run           = (state_q == ST_RUN);
        gnt0          = run & rd0_req_valid & (~rd1_req_valid | ~ptr_q);
        gnt1          = run & rd1_req_valid & (~rd0_req_valid | ptr_q);
        wr_fire       = run & wr_req_valid;
        gnt_addr      = gnt0 ? rd0_req_addr : rd1_req_addr;

        init_done     = run;
        wr_req_ready  = run;
        rd0_req_ready = gnt0;
        rd1_req_ready = gnt1;

        sram_r_en     = gnt0 | gnt1;
        sram_r_addr   = sram_r_en ? gnt_addr : r_addr_q;

        sram_w_en     = (state_q == ST_INIT) | wr_fire;
        sram_w_addr   = (state_q == ST_INIT) ? cnt_q : wr_req_addr;
        sram_w_data   = (state_q == ST_INIT) ? '0 : wr_req_data;

        rd0_resp_valid = rv0_q;
        rd1_resp_valid = rv1_q;
        rd0_resp_data  = byp_q ? byp_data_q : sram_r_data;
        rd1_resp_data  = byp_q ? byp_data_q : sram_r_data;
    end

    // The macro returns pre-write data on a same-address collision, so capture the write.
    always_comb begin
        r_addr_d   = sram_r_addr;
        rv0_d      = gnt0;
        rv1_d      = gnt1;
        ptr_d      = gnt0 ? 1'b1 : (gnt1 ? 1'b0 : ptr_q);
        byp_d      = wr_fire & sram_r_en & (wr_req_addr == gnt_addr);
        byp_data_d = byp_d ? wr_req_data : byp_data_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr_q   <= '0;
            ptr_q      <= 1'b0;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            r_addr_q   <= r_addr_d;
            ptr_q      <= ptr_d;
            rv0_q      <= rv0_d;
            rv1_q      <= rv1_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Bench for sram_array_ctrl: behavioural SRAM macro plus a golden-memory reference
// model checked every cycle, with directed steps followed by random traffic.
module tb_sram_array_ctrl;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 13;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              init_req = 1'b0;
    logic              init_done;
    logic              rd0_req_valid = 1'b0, rd0_req_ready, rd0_resp_valid;
    logic [ADDR_W-1:0] rd0_req_addr = '0;
    logic [DATA_W-1:0] rd0_resp_data;
    logic              rd1_req_valid = 1'b0, rd1_req_ready, rd1_resp_valid;
    logic [ADDR_W-1:0] rd1_req_addr = '0;
    logic [DATA_W-1:0] rd1_resp_data;
    logic              wr_req_valid = 1'b0, wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr = '0;
    logic [DATA_W-1:0] wr_req_data = '0;
    logic              sram_r_en, sram_w_en;
    logic [ADDR_W-1:0] sram_r_addr, sram_w_addr;
    logic [DATA_W-1:0] sram_r_data, sram_w_data;

    always #5 clock = ~clock;

    sram_array_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .init_req(init_req), .init_done(init_done),
        .rd0_req_valid(rd0_req_valid), .rd0_req_ready(rd0_req_ready), .rd0_req_addr(rd0_req_addr),
        .rd0_resp_valid(rd0_resp_valid), .rd0_resp_data(rd0_resp_data),
        .rd1_req_valid(rd1_req_valid), .rd1_req_ready(rd1_req_ready), .rd1_req_addr(rd1_req_addr),
        .rd1_resp_valid(rd1_resp_valid), .rd1_resp_data(rd1_resp_data),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
        .wr_req_data(wr_req_data),
        .sram_r_en(sram_r_en), .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
        .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data)
    );

    // Macro: synchronous read returning the pre-write contents on a collision.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (sram_w_en) mem[sram_w_addr] <= sram_w_data;
        if (sram_r_en) sram_r_data <= mem[sram_r_addr];
    end

    // Reference model: phase, clear position, favoured reader, golden contents, pending responses.
    typedef enum {M_WAIT, M_INIT, M_RUN} mode_t;
    mode_t             m_mode;
    int                m_cnt;
    bit                m_fav1;
    bit                m_ev0, m_ev1;
    logic [DATA_W-1:0] m_ed;
    logic [DATA_W-1:0] gm [DEPTH];
    bit                m_ra_known;
    logic [ADDR_W-1:0] m_last_ra;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode     = M_WAIT;
        m_cnt      = 0;
        m_fav1     = 1'b0;
        m_ev0      = 1'b0;
        m_ev1      = 1'b0;
        m_ra_known = 1'b0;
    endtask

    task automatic clear_inputs();
        init_req      = 1'b0;
        rd0_req_valid = 1'b0;
        rd1_req_valid = 1'b0;
        wr_req_valid  = 1'b0;
    endtask

    // Called at a falling edge with inputs applied; checks, advances the model, returns at next falling edge.
    task automatic cycle();
        bit                g0, g1, run, wf;
        logic [ADDR_W-1:0] ga;
        #1;
        run = (m_mode == M_RUN);
        g0  = run && rd0_req_valid && (!rd1_req_valid || !m_fav1);
        g1  = run && rd1_req_valid && (!rd0_req_valid || m_fav1);
        wf  = run && wr_req_valid;
        ga  = g0 ? rd0_req_addr : rd1_req_addr;

        chk("init_done", 32'(init_done), 32'(run));
        chk("rd0_ready", 32'(rd0_req_ready), 32'(g0));
        chk("rd1_ready", 32'(rd1_req_ready), 32'(g1));
        chk("wr_ready", 32'(wr_req_ready), 32'(run));
        chk("r_en", 32'(sram_r_en), 32'(g0 | g1));
        if (g0 || g1) chk("r_addr", 32'(sram_r_addr), 32'(ga));
        else if (m_ra_known) chk("r_addr_hold", 32'(sram_r_addr), 32'(m_last_ra));
        chk("w_en", 32'(sram_w_en), 32'((m_mode == M_INIT) || wf));
        if (m_mode == M_INIT) begin
            chk("clr_addr", 32'(sram_w_addr), 32'(m_cnt));
            chk("clr_data", 32'(sram_w_data), 32'h0);
        end
        if (wf) begin
            chk("w_addr", 32'(sram_w_addr), 32'(wr_req_addr));
            chk("w_data", 32'(sram_w_data), 32'(wr_req_data));
        end
        chk("rd0_resp_valid", 32'(rd0_resp_valid), 32'(m_ev0));
        chk("rd1_resp_valid", 32'(rd1_resp_valid), 32'(m_ev1));
        if (m_ev0) chk("rd0_resp_data", 32'(rd0_resp_data), 32'(m_ed));
        if (m_ev1) chk("rd1_resp_data", 32'(rd1_resp_data), 32'(m_ed));

        m_ev0 = g0;
        m_ev1 = g1;
        if (g0 || g1) begin
            m_ed       = (wf && wr_req_addr == ga) ? wr_req_data : gm[ga];
            m_last_ra  = ga;
            m_ra_known = 1'b1;
            m_fav1     = g0;
        end
        if (wf) gm[wr_req_addr] = wr_req_data;
        case (m_mode)
            M_WAIT: begin m_mode = M_INIT; m_cnt = 0; end
            M_INIT: begin
                gm[m_cnt] = '0;
                if (m_cnt == DEPTH - 1) m_mode = M_RUN;
                else m_cnt++;
            end
            M_RUN: if (init_req) begin m_mode = M_INIT; m_cnt = 0; end
            default: ;
        endcase
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_init_done"}, 32'(init_done), 32'h0);
        chk({tag, "_rd0_ready"}, 32'(rd0_req_ready), 32'h0);
        chk({tag, "_rd1_ready"}, 32'(rd1_req_ready), 32'h0);
        chk({tag, "_wr_ready"}, 32'(wr_req_ready), 32'h0);
        chk({tag, "_rd0_resp_valid"}, 32'(rd0_resp_valid), 32'h0);
        chk({tag, "_rd1_resp_valid"}, 32'(rd1_resp_valid), 32'h0);
        chk({tag, "_w_en"}, 32'(sram_w_en), 32'h0);
        chk({tag, "_r_en"}, 32'(sram_r_en), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        rd0_req_valid = 1'b1;
        wr_req_valid  = 1'b1;
        init_req      = 1'b1;
        #12;
        check_reset_outputs("reset");
        clear_inputs();
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        // One WAIT cycle, then the full clear.
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        #1 chk("init_done_after_clear", 32'(init_done), 32'h1);
        @(negedge clock);

        // Write 5, then read 5 and 6 on rd0.
        wr_req_valid = 1'b1; wr_req_addr = 10'd5; wr_req_data = 13'h1ABC;
        cycle();
        clear_inputs();
        rd0_req_valid = 1'b1; rd0_req_addr = 10'd5;
        cycle();
        rd0_req_addr = 10'd6;
        chk("rd0_addr5_valid", 32'(rd0_resp_valid), 32'h1);
        chk("rd0_addr5_data", 32'(rd0_resp_data), 32'h1ABC);
        cycle();
        clear_inputs();
        chk("rd0_addr6_data", 32'(rd0_resp_data), 32'h0);
        cycle();

        // Both readers every cycle: grants alternate.
        rd0_req_valid = 1'b1; rd0_req_addr = 10'd5;
        rd1_req_valid = 1'b1; rd1_req_addr = 10'd6;
        for (int i = 0; i < 6; i++) cycle();
        clear_inputs();
        cycle();

        // Same-cycle write and read of address 9 (bypass).
        wr_req_valid = 1'b1; wr_req_addr = 10'd9; wr_req_data = 13'h0F0F;
        rd1_req_valid = 1'b1; rd1_req_addr = 10'd9;
        cycle();
        clear_inputs();
        chk("bypass_valid", 32'(rd1_resp_valid), 32'h1);
        chk("bypass_data", 32'(rd1_resp_data), 32'h0F0F);
        cycle();

        // Read 3, then write 3 next cycle: response keeps the old value.
        rd0_req_valid = 1'b1; rd0_req_addr = 10'd3;
        cycle();
        clear_inputs();
        wr_req_valid = 1'b1; wr_req_addr = 10'd3; wr_req_data = 13'h0055;
        chk("late_write_data", 32'(rd0_resp_data), 32'h0);
        cycle();
        clear_inputs();
        cycle();

        // init_req alongside a read; the read still completes during the clear.
        init_req = 1'b1; rd0_req_valid = 1'b1; rd0_req_addr = 10'd3; wr_req_valid = 1'b1;
        cycle();
        chk("last_read_resp_valid", 32'(rd0_resp_valid), 32'h1);
        chk("last_read_resp_data", 32'(rd0_resp_data), 32'h0055);
        for (int i = 0; i < 4; i++) cycle();

        // Asynchronous reset in the middle of the clear.
        #3 reset = 1'b0;
        #1 check_reset_outputs("mid_init_reset");
        clear_inputs();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < DEPTH + 1; i++) cycle();

        for (int i = 0; i < 3000; i++) begin
            rd0_req_valid = 1'($urandom_range(0, 1));
            rd1_req_valid = 1'($urandom_range(0, 1));
            wr_req_valid  = 1'($urandom_range(0, 1));
            rd0_req_addr  = ADDR_W'($urandom_range(0, 15));
            rd1_req_addr  = ADDR_W'($urandom_range(0, 15));
            wr_req_addr   = ADDR_W'($urandom_range(0, 15));
            wr_req_data   = DATA_W'($urandom);
            init_req      = ($urandom_range(0, 499) == 0);
            cycle();
        end
        clear_inputs();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
